tx_serial_8n1: RTL and testbench
================================

Name: tx_serial_8N1

Overview:
- Asynchronous serial transmitter, 8 data bits, no parity, configurable stop bits (8N1 by default). Counterpart of rx_serial_8N1.
- Accepts a byte on a single-cycle start request and shifts it out LSB first on the TX line at the configured baud rate. Signals completion with a one-cycle pulse.
- Sits between the robot-control logic and the UART pin. Its output is loop-back compatible with rx_serial_8N1 at 50 MHz / 115200 baud.

Parameters:
- CLOCK_DIV, 434: clock cycles per serial bit (50 MHz / 115200 baud). Must be ≥ 2.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clock  in  1  system clock, 50 MHz, rising edge.
- reset  in  1  asynchronous, active-high reset.
- partida  in  1  transmit request; sampled on the rising edge.
- dados_ascii  in  8  byte to send; latched when partida is accepted.
- saida_serial  out  1  TX line; idle high.
- pronto  out  1  one-cycle pulse after the last stop bit.
- ocupado  out  1  high from acceptance until pronto.
- db_estado  out  4  current FSM state encoding.
- db_tick  out  1  baud tick, for debug.
- db_saida_serial  out  1  copy of saida_serial.

Behaviour:
- Reset (async, any time, including mid-frame):
  - state = INICIAL; saida_serial = 1; pronto = 0; ocupado = 0.
  - Baud counter = 0; bit counter = 0; shift register = 0x00; db_tick = 0.
  - saida_serial returns high immediately, without waiting for a clock edge.
- FSM states and encodings: INICIAL=0, INICIO=1, DADOS=2, PARADA=3, FINAL=4. All other codes go to INICIAL.
- INICIAL:
  - saida_serial = 1.
  - partida = 1 at edge k: latch dados_ascii into the shift register, clear the baud counter, go to INICIO.
  - saida_serial is registered: it drives 0 from edge k onward (visible in cycle k+1).
- Baud counter: counts 0..CLOCK_DIV-1 and wraps. Tick = counter at CLOCK_DIV-1. The counter restarts at every accepted partida, so each bit lasts exactly CLOCK_DIV cycles.
- INICIO: drives 0. On tick go to DADOS with bit counter = 0.
- DADOS:
  - Drives shift[0].
  - On tick: shift right, increment the bit counter. After the 8th tick go to PARADA.
  - Bit order is LSB first: d0..d7.
- PARADA: drives 1. Stays for STOP_BITS ticks, then goes to FINAL.
- FINAL:
  - Exactly one cycle. pronto = 1, saida_serial = 1. Then back to INICIAL.
  - ocupado drops in the same cycle that pronto is high.
- Timing: from saida_serial falling to the pronto pulse = (9 + STOP_BITS) × CLOCK_DIV cycles. The minimum idle gap between frames is 2 cycles (FINAL + INICIAL).
- Busy handling:
  - partida while ocupado = 1 (INICIO..FINAL) is ignored; no queueing.
  - Changes on dados_ascii after acceptance do not affect the frame in flight.
- partida held high continuously: a new frame starts on the first INICIAL cycle after each FINAL.
- pronto and ocupado never assert outside the sequence above. pronto never asserts after a reset-aborted frame.

Test Plan:
1. Reset, then partida pulse with dados_ascii = 0x35, CLOCK_DIV = 434:
   - saida_serial = 0,1,0,1,0,1,1,0,0,1 (start, LSB first, stop), each bit 434 cycles.
   - pronto pulses once, 4340 cycles after the falling edge.
2. Loop-back into rx_serial_8N1, sending 0xB5 then 0xAA back to back (partida held high):
   - Receiver pronto fires twice with dados_ascii = 0xB5, then 0xAA.
   - Inter-frame idle gap is 2 cycles.
3. partida pulse with 0x0F; in the middle of DADOS, partida again with 0xFF:
   - Line carries only 0x0F; one pronto; the second request is dropped.
4. During DADOS of 0xD5, assert reset for 5 cycles:
   - saida_serial = 1 asynchronously; pronto never pulses; db_estado = 0.
   - A subsequent partida with 0x21 sends a clean frame.
5. STOP_BITS = 2, CLOCK_DIV = 4, byte 0x00:
   - Low for 36 cycles, high for 8 cycles, then pronto.
   - Frame length 44 cycles; ocupado high throughout.

Source files
------------

// File: rtl/tx_serial_8n1.sv
// ---------------------------------------------------------------------------
// tx_serial_8n1 -- asynchronous serial transmitter, 8 data bits, no parity,
// STOP_BITS stop bits. A byte is accepted on a one-cycle partida request and
// shifted out LSB first, each bit lasting CLOCK_DIV clock cycles.
//
// Ports
//   clock           in   system clock, rising edge
//   reset           in   asynchronous, active-high reset
//   partida         in   transmit request, honoured only when idle
//   dados_ascii     in   byte to send, latched on acceptance
//   saida_serial    out  TX line, idle high
//   pronto          out  one-cycle pulse after the last stop bit
//   ocupado         out  high from acceptance until pronto
//   db_estado       out  current FSM state encoding
//   db_tick         out  baud tick
//   db_saida_serial out  copy of saida_serial
// ---------------------------------------------------------------------------
module tx_serial_8n1 #(
    parameter int unsigned CLOCK_DIV = 434,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados_ascii,
    output logic       saida_serial,
    output logic       pronto,
    output logic       ocupado,
    output logic [3:0] db_estado,
    output logic       db_tick,
    output logic       db_saida_serial
);

    localparam int unsigned CNT_W = $clog2(CLOCK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLOCK_DIV - 1);
    localparam logic [3:0] BIT_LAST  = 4'd7;
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        INICIO  = 4'd1,
        DADOS   = 4'd2,
        PARADA  = 4'd3,
        FINAL   = 4'd4
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             saida_q, saida_d;
    logic             pronto_q, pronto_d;
    logic             ocupado_q, ocupado_d;
    logic             tick_q, tick_d;
    logic             tick_c;

    assign tick_c = (cnt_q == CNT_MAX);

    // State and output registers; the line goes high as soon as reset rises.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= INICIAL;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            saida_q   <= 1'b1;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            saida_q   <= saida_d;
            pronto_q  <= pronto_d;
            ocupado_q <= ocupado_d;
            tick_q    <= tick_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so the
    // registered line changes on the same edge as the state.
    always_comb begin
        estado_d  = estado_q;
        cnt_d     = '0;
        bit_d     = bit_q;
        shift_d   = shift_q;
        saida_d   = 1'b1;
        pronto_d  = 1'b0;
        ocupado_d = 1'b0;
        tick_d    = 1'b0;

        case (estado_q)
            INICIAL: begin
                if (partida) begin
                    shift_d  = dados_ascii;
                    estado_d = INICIO;
                end
            end
            INICIO: begin
                if (tick_c) begin
                    estado_d = DADOS;
                    bit_d    = '0;
                end
            end
            DADOS: begin
                if (tick_c) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        estado_d = PARADA;
                        bit_d    = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            PARADA: begin
                if (tick_c) begin
                    if (bit_q == STOP_LAST) begin
                        estado_d = FINAL;
                        bit_d    = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            FINAL: begin
                estado_d = INICIAL;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase

        // Baud counter runs only while a frame is on the line, so it is
        // always zero at acceptance and every bit lasts CLOCK_DIV cycles.
        if (estado_q == INICIO || estado_q == DADOS || estado_q == PARADA) begin
            cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
        end

        case (estado_d)
            INICIO:  saida_d = 1'b0;
            DADOS:   saida_d = shift_d[0];
            default: saida_d = 1'b1;
        endcase

        pronto_d  = (estado_d == FINAL);
        ocupado_d = (estado_d == INICIO) || (estado_d == DADOS) || (estado_d == PARADA);
        tick_d    = (cnt_d == CNT_MAX);
    end

    assign saida_serial    = saida_q;
    assign db_saida_serial = saida_q;
    assign pronto          = pronto_q;
    assign ocupado         = ocupado_q;
    assign db_estado       = estado_q;
    assign db_tick         = tick_q;

endmodule

// File: tb/tb_tx_serial_8n1.sv
// ---------------------------------------------------------------------------
// tb_tx_serial_8n1 -- directed bench for tx_serial_8n1. Instance A runs at
// 50 MHz / 115200 baud with one stop bit; instance B uses CLOCK_DIV = 4 and
// two stop bits. Frames are compared cycle by cycle against hand-written
// line patterns {stop bits, d7..d0, start}.
// ---------------------------------------------------------------------------
module tb_tx_serial_8n1;

    localparam int unsigned DA = 434;
    localparam int unsigned SA = 1;
    localparam int unsigned DB = 4;
    localparam int unsigned SB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, partida_a, line_a, pronto_a, ocupado_a, tick_a, dbline_a;
    logic [7:0] dados_a;
    logic [3:0] estado_a;
    logic       rst_b, partida_b, line_b, pronto_b, ocupado_b, tick_b, dbline_b;
    logic [7:0] dados_b;
    logic [3:0] estado_b;

    tx_serial_8n1 #(.CLOCK_DIV(DA), .STOP_BITS(SA)) u_a (
        .clock(clk), .reset(rst_a), .partida(partida_a), .dados_ascii(dados_a),
        .saida_serial(line_a), .pronto(pronto_a), .ocupado(ocupado_a),
        .db_estado(estado_a), .db_tick(tick_a), .db_saida_serial(dbline_a)
    );

    tx_serial_8n1 #(.CLOCK_DIV(DB), .STOP_BITS(SB)) u_b (
        .clock(clk), .reset(rst_b), .partida(partida_b), .dados_ascii(dados_b),
        .saida_serial(line_b), .pronto(pronto_b), .ocupado(ocupado_b),
        .db_estado(estado_b), .db_tick(tick_b), .db_saida_serial(dbline_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [10:0] exp_line;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_line(input int sel);
        return (sel != 0) ? line_b : line_a;
    endfunction
    function automatic logic get_dbline(input int sel);
        return (sel != 0) ? dbline_b : dbline_a;
    endfunction
    function automatic logic get_pronto(input int sel);
        return (sel != 0) ? pronto_b : pronto_a;
    endfunction
    function automatic logic get_ocupado(input int sel);
        return (sel != 0) ? ocupado_b : ocupado_a;
    endfunction
    function automatic logic get_tick(input int sel);
        return (sel != 0) ? tick_b : tick_a;
    endfunction
    function automatic logic [3:0] get_estado(input int sel);
        return (sel != 0) ? estado_b : estado_a;
    endfunction

    task automatic set_req(input int sel, input logic p, input logic [7:0] d);
        if (sel != 0) begin
            partida_b = p;
            dados_b   = d;
        end else begin
            partida_a = p;
            dados_a   = d;
        end
    endtask

    // One-cycle request; returns just after the accepting edge.
    task automatic send(input int sel, input logic [7:0] d);
        @(posedge clk);
        #1 set_req(sel, 1'b1, d);
        @(posedge clk);
        #1 set_req(sel, 1'b0, 8'h00);
    endtask

    // Follows one frame from the cycle after acceptance through FINAL and the
    // following INICIAL cycle. Optionally pulses a request at cycle inj_at.
    task automatic check_frame(input int sel, input logic [10:0] exp_line, input string name,
                               input int inj_at, input logic [7:0] inj_data);
        int          d      = (sel != 0) ? int'(DB) : int'(DA);
        int          nb     = 9 + ((sel != 0) ? int'(SB) : int'(SA));
        int          e_line = 0;
        int          e_busy = 0;
        int          e_tick = 0;
        logic [3:0]  idx;
        logic [10:0] cap    = '0;
        logic [10:0] mask   = (nb == 11) ? 11'h7FF : 11'h3FF;
        logic        tick_exp;
        for (int j = 1; j <= nb * d; j++) begin
            @(negedge clk);
            idx      = 4'((j - 1) / d);
            tick_exp = ((j % d) == 0);
            if (get_line(sel) !== exp_line[idx]) e_line++;
            if (get_dbline(sel) !== get_line(sel)) e_line++;
            if (get_ocupado(sel) !== 1'b1 || get_pronto(sel) !== 1'b0) e_busy++;
            if (get_tick(sel) !== tick_exp) e_tick++;
            if (((j - 1) % d) == d / 2) cap[idx] = get_line(sel);
            if (inj_at != 0 && j == inj_at) set_req(sel, 1'b1, inj_data);
            if (inj_at != 0 && j == inj_at + 1) set_req(sel, 1'b0, 8'h00);
        end
        check({name, " line timing errors"}, 32'(e_line), 32'd0);
        check({name, " busy/pronto errors"}, 32'(e_busy), 32'd0);
        check({name, " tick errors"}, 32'(e_tick), 32'd0);
        check({name, " mid-bit samples"}, 32'(cap & mask), 32'(exp_line & mask));
        @(negedge clk);
        check({name, " pronto in FINAL"}, 32'(get_pronto(sel)), 32'd1);
        check({name, " ocupado in FINAL"}, 32'(get_ocupado(sel)), 32'd0);
        check({name, " line in FINAL"}, 32'(get_line(sel)), 32'd1);
        check({name, " state FINAL"}, 32'(get_estado(sel)), 32'd4);
        @(negedge clk);
        check({name, " pronto single pulse"}, 32'(get_pronto(sel)), 32'd0);
        check({name, " line idle"}, 32'(get_line(sel)), 32'd1);
        check({name, " state INICIAL"}, 32'(get_estado(sel)), 32'd0);
    endtask

    initial begin
        int err;

        rst_a = 1'b1; partida_a = 1'b0; dados_a = 8'h00;
        rst_b = 1'b1; partida_b = 1'b0; dados_b = 8'h00;

        vecs[0] = '{0, 8'h35, 11'b11_00110101_0};
        vecs[1] = '{0, 8'h80, 11'b11_10000000_0};
        vecs[2] = '{0, 8'h01, 11'b11_00000001_0};
        vecs[3] = '{1, 8'h00, 11'b11_00000000_0};
        vecs[4] = '{1, 8'h96, 11'b11_10010110_0};
        vecs[5] = '{1, 8'hFF, 11'b11_11111111_0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst%0d line", s), 32'(get_line(s)), 32'd1);
            check($sformatf("rst%0d pronto", s), 32'(get_pronto(s)), 32'd0);
            check($sformatf("rst%0d ocupado", s), 32'(get_ocupado(s)), 32'd0);
            check($sformatf("rst%0d estado", s), 32'(get_estado(s)), 32'd0);
            check($sformatf("rst%0d tick", s), 32'(get_tick(s)), 32'd0);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);

        // Table-driven single frames
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].sel, vecs[i].data);
            check_frame(vecs[i].sel, vecs[i].exp_line, $sformatf("vec%0d", i), 0, 8'h00);
            repeat (3) @(posedge clk);
        end

        // Back-to-back frames with partida held high; data changes after acceptance
        @(posedge clk);
        #1 set_req(0, 1'b1, 8'hB5);
        @(posedge clk);
        #1 dados_a = 8'hAA;
        check_frame(0, 11'b11_10110101_0, "b2b_first", 0, 8'h00);
        check_frame(0, 11'b11_10101010_0, "b2b_second", 0, 8'h00);
        set_req(0, 1'b0, 8'h00);
        err = 0;
        repeat (2 * DA) begin
            @(negedge clk);
            if (line_a !== 1'b1 || ocupado_a !== 1'b0 || pronto_a !== 1'b0) err++;
        end
        check("b2b no third frame", 32'(err), 32'd0);

        // Request during DADOS is dropped
        send(0, 8'h0F);
        check_frame(0, 11'b11_00001111_0, "busy_drop", 5 * DA, 8'hFF);
        err = 0;
        repeat (2 * DA) begin
            @(negedge clk);
            if (line_a !== 1'b1 || ocupado_a !== 1'b0 || pronto_a !== 1'b0) err++;
        end
        check("busy_drop no second frame", 32'(err), 32'd0);

        // Reset in the middle of DADOS (bit d1 of 0xD5 is low)
        send(0, 8'hD5);
        repeat (2 * DA + DA / 2) @(negedge clk);
        check("pre-reset line low", 32'(line_a), 32'd0);
        #1 rst_a = 1'b1;
        #1;
        check("async reset line", 32'(line_a), 32'd1);
        check("async reset estado", 32'(estado_a), 32'd0);
        check("async reset ocupado", 32'(ocupado_a), 32'd0);
        err = 0;
        repeat (5) begin
            @(negedge clk);
            if (line_a !== 1'b1 || pronto_a !== 1'b0 || estado_a !== 4'd0) err++;
        end
        check("reset hold", 32'(err), 32'd0);
        rst_a = 1'b0;
        err = 0;
        repeat (12 * DA) begin
            @(negedge clk);
            if (line_a !== 1'b1 || pronto_a !== 1'b0 || ocupado_a !== 1'b0) err++;
        end
        check("no pronto after abort", 32'(err), 32'd0);
        send(0, 8'h21);
        check_frame(0, 11'b11_00100001_0, "post_reset", 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
